// File: rtl/sv_uart_frame_pkg.sv
// Shared types and defaults for the UART frame decoder:
// parser states, buffer entry layout and the running checksum.
package sv_uart_frame_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      LEN     = 3'd1,
      PAYLOAD = 3'd2,
      CHK     = 3'd3,
      SKIP    = 3'd4
   } state_e;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } entry_t;

   function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
      return sum + data;
   endfunction

endpackage

// File: rtl/sv_uart_frame_buf.sv
// Commit/rewind FIFO: speculative writes become visible to the reader only
// after commit; rewind discards everything written since the last commit.
module sv_uart_frame_buf
   import sv_uart_frame_pkg::*;
#(
   parameter int BUF_AW = 7
) (
   input  logic   iclk,
   input  logic   irst,
   input  logic   wr_en,
   input  entry_t wr_entry,
   output logic   wr_space,
   input  logic   commit,
   input  logic   rewind,
   output entry_t rd_entry,
   output logic   rd_valid,
   input  logic   rd_ready
);

   localparam int            PW    = BUF_AW + 1;
   localparam logic [PW-1:0] DEPTH = PW'(2**BUF_AW);

   entry_t        mem_r [2**BUF_AW];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] wr_cmt_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] rd_next_s;
   logic [PW-1:0] fill_s;
   logic          pop_s;
   logic          rd_valid_r;
   entry_t        rd_entry_r;

   // rd_ptr addresses the entry held in the output stage, so fill counts it too
   assign fill_s    = wr_ptr_r - rd_ptr_r;
   assign wr_space  = (fill_s < DEPTH);
   assign pop_s     = rd_valid_r & rd_ready;
   assign rd_next_s = rd_ptr_r + {{BUF_AW{1'b0}}, pop_s};
   assign rd_valid  = rd_valid_r;
   assign rd_entry  = rd_entry_r;

   // Speculative write pointer and committed boundary
   always_ff @(posedge iclk) begin
      if (irst) begin
         wr_ptr_r <= '0;
         wr_cmt_r <= '0;
      end else begin
         if (rewind) begin
            wr_ptr_r <= wr_cmt_r;
         end else if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (commit) begin
            wr_cmt_r <= wr_ptr_r;
         end
      end
   end

   // Storage array
   always_ff @(posedge iclk) begin
      if (wr_en && !rewind) begin
         mem_r[wr_ptr_r[BUF_AW-1:0]] <= wr_entry;
      end
   end

   // Registered first-word-fall-through output stage
   always_ff @(posedge iclk) begin
      if (irst) begin
         rd_ptr_r   <= '0;
         rd_valid_r <= 1'b0;
         rd_entry_r <= '0;
      end else begin
         rd_ptr_r   <= rd_next_s;
         rd_valid_r <= (rd_next_s != wr_cmt_r);
         rd_entry_r <= mem_r[rd_next_s[BUF_AW-1:0]];
      end
   end

endmodule

// File: rtl/sv_uart_frame_rx.sv
// Framed-packet decoder: SYNC, LEN, payload, CHK. Payload is staged in a
// commit/rewind buffer and released on m_axis only once the checksum matches.
module sv_uart_frame_rx
   import sv_uart_frame_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
   parameter int         MAX_LEN   = 64,
   parameter int         BUF_AW    = 7,
   parameter int         TMO_W     = 24
) (
   input  logic             iclk,
   input  logic             irst,
   input  logic [7:0]       s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [7:0]       m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   input  logic [TMO_W-1:0] itimeout,
   output logic             oframe_ok,
   output logic             oerr_chk,
   output logic             oerr_len,
   output logic             oerr_ovf,
   output logic             oerr_tmo
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   if (MAX_LEN < 1 || MAX_LEN > 255 || (2**BUF_AW) < MAX_LEN) begin : g_param_check
      $error("sv_uart_frame_rx: MAX_LEN must be 1..255 and fit in 2**BUF_AW entries");
   end

   state_e           state_r, state_n;
   logic [7:0]       len_r, len_n, cnt_r, cnt_n, sum_r, sum_n, skip_r, skip_n;
   logic [TMO_W-1:0] idle_r, idle_n;
   logic             tready_r, acc_s, last_s;
   logic             wr_en_s, commit_s, rewind_s, space_s;
   entry_t           wr_entry_s, rd_entry_s;
   logic             ok_s, echk_s, elen_s, eovf_s, etmo_s;
   logic             ok_r, echk_r, elen_r, eovf_r, etmo_r;

   assign acc_s  = s_axis_tvalid & tready_r;
   assign last_s = (cnt_r == len_r - 8'd1);

   // Parser next-state, buffer strobes and event pulses
   always_comb begin
      state_n         = state_r;
      len_n           = len_r;
      cnt_n           = cnt_r;
      sum_n           = sum_r;
      skip_n          = skip_r;
      wr_en_s         = 1'b0;
      wr_entry_s.last = last_s;
      wr_entry_s.data = s_axis_tdata;
      commit_s        = 1'b0;
      rewind_s        = 1'b0;
      ok_s            = 1'b0;
      echk_s          = 1'b0;
      elen_s          = 1'b0;
      eovf_s          = 1'b0;
      etmo_s          = 1'b0;
      if (state_r == HUNT) begin
         idle_n = '0;
      end else begin
         idle_n = idle_r + TMO_W'(1);
      end
      if (acc_s) begin
         idle_n = '0;
         case (state_r)
            HUNT: begin
               if (s_axis_tdata == SYNC_BYTE) begin
                  state_n = LEN;
               end else begin
                  state_n = HUNT;
               end
            end
            LEN: begin
               if (s_axis_tdata == 8'd0 || s_axis_tdata > MAX_LEN_B) begin
                  elen_s  = 1'b1;
                  state_n = HUNT;
               end else begin
                  len_n   = s_axis_tdata;
                  sum_n   = s_axis_tdata;
                  cnt_n   = 8'd0;
                  state_n = PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (space_s) begin
                  wr_en_s = 1'b1;
                  sum_n   = chk_add(sum_r, s_axis_tdata);
                  cnt_n   = cnt_r + 8'd1;
                  if (last_s) begin
                     state_n = CHK;
                  end else begin
                     state_n = PAYLOAD;
                  end
               end else begin
                  // remaining payload bytes plus the CHK byte still arrive
                  rewind_s = 1'b1;
                  eovf_s   = 1'b1;
                  skip_n   = len_r - cnt_r;
                  state_n  = SKIP;
               end
            end
            CHK: begin
               if (s_axis_tdata == sum_r) begin
                  commit_s = 1'b1;
                  ok_s     = 1'b1;
               end else begin
                  rewind_s = 1'b1;
                  echk_s   = 1'b1;
               end
               state_n = HUNT;
            end
            SKIP: begin
               if (skip_r == 8'd1) begin
                  state_n = HUNT;
               end else begin
                  skip_n  = skip_r - 8'd1;
                  state_n = SKIP;
               end
            end
            default: begin
               state_n = HUNT;
            end
         endcase
      end else if (state_r != HUNT && itimeout != '0 && idle_r == itimeout) begin
         rewind_s = 1'b1;
         etmo_s   = 1'b1;
         idle_n   = '0;
         state_n  = HUNT;
      end else begin
         state_n = state_r;
      end
   end

   // Parser state, counters and registered pulses
   always_ff @(posedge iclk) begin
      if (irst) begin
         state_r  <= HUNT;
         len_r    <= 8'd0;
         cnt_r    <= 8'd0;
         sum_r    <= 8'd0;
         skip_r   <= 8'd0;
         idle_r   <= '0;
         tready_r <= 1'b0;
         ok_r     <= 1'b0;
         echk_r   <= 1'b0;
         elen_r   <= 1'b0;
         eovf_r   <= 1'b0;
         etmo_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         len_r    <= len_n;
         cnt_r    <= cnt_n;
         sum_r    <= sum_n;
         skip_r   <= skip_n;
         idle_r   <= idle_n;
         tready_r <= 1'b1;
         ok_r     <= ok_s;
         echk_r   <= echk_s;
         elen_r   <= elen_s;
         eovf_r   <= eovf_s;
         etmo_r   <= etmo_s;
      end
   end

   sv_uart_frame_buf #(
      .BUF_AW(BUF_AW)
   ) u_buf (
      .iclk    (iclk),
      .irst    (irst),
      .wr_en   (wr_en_s),
      .wr_entry(wr_entry_s),
      .wr_space(space_s),
      .commit  (commit_s),
      .rewind  (rewind_s),
      .rd_entry(rd_entry_s),
      .rd_valid(m_axis_tvalid),
      .rd_ready(m_axis_tready)
   );

   assign s_axis_tready = tready_r;
   assign m_axis_tdata  = rd_entry_s.data;
   assign m_axis_tlast  = rd_entry_s.last;
   assign oframe_ok     = ok_r;
   assign oerr_chk      = echk_r;
   assign oerr_len      = elen_r;
   assign oerr_ovf      = eovf_r;
   assign oerr_tmo      = etmo_r;

endmodule

// File: tb/tb_sv_uart_frame_rx.sv
// Directed bench: a frame-level model predicts pulses and the released payload
// stream; one negedge process compares every cycle against it.
module tb_sv_uart_frame_rx;

   localparam int         TMO_W  = 24;
   localparam logic [4:0] EV_OK  = 5'b10000;
   localparam logic [4:0] EV_CHK = 5'b01000;
   localparam logic [4:0] EV_LEN = 5'b00100;
   localparam logic [4:0] EV_OVF = 5'b00010;
   localparam logic [4:0] EV_TMO = 5'b00001;

   logic             iclk = 1'b0;
   logic             irst = 1'b1;
   logic [7:0]       s_axis_tdata = 8'd0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic [7:0]       m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready = 1'b0;
   logic             m_axis_tlast;
   logic [TMO_W-1:0] itimeout = '0;
   logic             oframe_ok, oerr_chk, oerr_len, oerr_ovf, oerr_tmo;

   sv_uart_frame_rx #(
      .SYNC_BYTE(8'hA5), .MAX_LEN(64), .BUF_AW(7), .TMO_W(TMO_W)
   ) dut (
      .iclk(iclk), .irst(irst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .itimeout(itimeout),
      .oframe_ok(oframe_ok), .oerr_chk(oerr_chk), .oerr_len(oerr_len),
      .oerr_ovf(oerr_ovf), .oerr_tmo(oerr_tmo)
   );

   always #5 iclk = ~iclk;

   int cyc = 0;
   always @(posedge iclk) cyc <= cyc + 1;

   int         n_cmp = 0;
   int         n_err = 0;
   int         n_out = 0;
   int         n_last = 0;
   int         model_occ = 0;
   bit         checking = 1'b0;
   bit         prev_stall = 1'b0;
   logic [8:0] prev_beat = 9'd0;
   logic [4:0] exp_ev [int];
   logic [8:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // every-cycle comparison of pulses and the output stream against the model
   always @(negedge iclk) begin
      logic [4:0] act_ev, want_ev;
      logic [8:0] beat;
      if (checking) begin
         act_ev  = {oframe_ok, oerr_chk, oerr_len, oerr_ovf, oerr_tmo};
         want_ev = exp_ev.exists(cyc) ? exp_ev[cyc] : 5'b00000;
         check("pulses", 32'(act_ev), 32'(want_ev));
         beat = {m_axis_tlast, m_axis_tdata};
         if (prev_stall) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_data", 32'(beat), 32'(prev_beat));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_out++;
            if (m_axis_tlast) n_last++;
            if (model_occ > 0) model_occ--;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL beat: got %0h want no output (cycle %0d)", beat, cyc);
            end else begin
               check("beat", 32'(beat), 32'(exp_q.pop_front()));
            end
         end
         prev_stall = m_axis_tvalid & ~m_axis_tready & ~irst;
         prev_beat  = beat;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge iclk);
      #1;
   endtask

   // byte presented in cycle cyc is accepted at the next edge
   task automatic drive_byte(input logic [7:0] b);
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      tick(1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic expect_ev(input int c, input logic [4:0] ev);
      if (exp_ev.exists(c)) exp_ev[c] = exp_ev[c] | ev;
      else exp_ev[c] = ev;
   endtask

   // frame model: checksum = LEN + payload (mod 256); payload[i] = seed + i*step
   task automatic send_frame(input logic [7:0] len_b, input logic [7:0] seed,
                             input logic [7:0] step, input logic [7:0] chk_xor);
      logic [7:0] sum, b;
      logic [8:0] beats [$];
      bit         ovf;
      drive_byte(8'hA5);
      if (len_b == 8'd0 || len_b > 8'd64) begin
         expect_ev(cyc + 1, EV_LEN);
         drive_byte(len_b);
      end else begin
         sum = len_b;
         ovf = 1'b0;
         drive_byte(len_b);
         for (int i = 0; i < int'(len_b); i++) begin
            b = seed + 8'(i) * step;
            if (!ovf && model_occ + i >= 128) begin
               ovf = 1'b1;
               expect_ev(cyc + 1, EV_OVF);
            end
            sum = sum + b;
            beats.push_back({(i == int'(len_b) - 1), b});
            drive_byte(b);
         end
         if (!ovf) begin
            if (chk_xor == 8'd0) begin
               expect_ev(cyc + 1, EV_OK);
               model_occ += int'(len_b);
               foreach (beats[j]) exp_q.push_back(beats[j]);
            end else begin
               expect_ev(cyc + 1, EV_CHK);
            end
         end
         drive_byte(sum ^ chk_xor);
      end
   endtask

   initial begin
      int base, base_last, k;

      // reset state
      tick(3);
      @(negedge iclk);
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_pulses", 32'({oframe_ok, oerr_chk, oerr_len, oerr_ovf, oerr_tmo}), 32'd0);
      check("rst_m_data", 32'({m_axis_tlast, m_axis_tdata}), 32'd0);
      @(posedge iclk); #1;
      irst = 1'b0;
      checking = 1'b1;
      @(negedge iclk);
      check("s_tready_last_rst", 32'(s_axis_tready), 32'd0);
      @(posedge iclk); #1;
      @(negedge iclk);
      check("s_tready_up", 32'(s_axis_tready), 32'd1);
      m_axis_tready = 1'b1;
      tick(2);

      // 1: good frame A5 03 11 22 33 69
      base = n_out;
      send_frame(8'd3, 8'h11, 8'h11, 8'h00);
      @(negedge iclk);
      check("t1_ok_pulse", 32'(oframe_ok), 32'd1);
      check("t1_tvalid_early", 32'(m_axis_tvalid), 32'd0);
      @(negedge iclk);
      check("t1_tvalid_rise", 32'(m_axis_tvalid), 32'd1);
      check("t1_first_byte", 32'({m_axis_tlast, m_axis_tdata}), 32'h011);
      tick(10);
      check("t1_count", 32'(n_out - base), 32'd3);

      // 2: bad checksum 6A, then a good frame
      base = n_out;
      send_frame(8'd3, 8'h11, 8'h11, 8'h03);
      tick(5);
      send_frame(8'd3, 8'h11, 8'h11, 8'h00);
      tick(10);
      check("t2_count", 32'(n_out - base), 32'd3);

      // 3: junk, LEN 0, LEN 65, LEN=A5 (not re-taken as SYNC), then good
      base = n_out;
      drive_byte(8'h00);
      drive_byte(8'hFF);
      send_frame(8'd0, 8'h00, 8'h00, 8'h00);
      send_frame(8'h41, 8'h00, 8'h00, 8'h00);
      send_frame(8'hA5, 8'h00, 8'h00, 8'h00);
      drive_byte(8'h03); drive_byte(8'h11); drive_byte(8'h22);
      drive_byte(8'h33); drive_byte(8'h69);
      tick(5);
      send_frame(8'd4, 8'h21, 8'h03, 8'h00);
      tick(10);
      check("t3_count", 32'(n_out - base), 32'd4);

      // 4: timeout after A5 02 11 with itimeout=100
      base = n_out;
      itimeout = 24'd100;
      drive_byte(8'hA5);
      drive_byte(8'h02);
      k = cyc;
      drive_byte(8'h11);
      expect_ev(k + 102, EV_TMO);
      tick(150);
      send_frame(8'd2, 8'h11, 8'h11, 8'h00);
      tick(10);
      // byte arriving exactly when the idle count reaches itimeout wins
      itimeout = 24'd5;
      drive_byte(8'hA5);
      drive_byte(8'h02);
      drive_byte(8'h11);
      tick(5);
      drive_byte(8'h22);
      expect_ev(cyc + 1, EV_OK);
      drive_byte(8'h35);
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h122);
      model_occ += 2;
      tick(10);
      // itimeout=0 disables the timeout
      itimeout = 24'd0;
      drive_byte(8'hA5);
      drive_byte(8'h02);
      drive_byte(8'h11);
      tick(150);
      drive_byte(8'h22);
      expect_ev(cyc + 1, EV_OK);
      drive_byte(8'h35);
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h122);
      model_occ += 2;
      tick(10);
      check("t4_count", 32'(n_out - base), 32'd6);

      // 5: overflow under backpressure
      m_axis_tready = 1'b0;
      tick(2);
      base = n_out;
      base_last = n_last;
      send_frame(8'd64, 8'h40, 8'h01, 8'h00);
      send_frame(8'd64, 8'h80, 8'h01, 8'h00);
      send_frame(8'd64, 8'hC0, 8'h01, 8'h00);
      tick(5);
      m_axis_tready = 1'b1;
      tick(200);
      check("t5_count", 32'(n_out - base), 32'd128);
      check("t5_tlast_count", 32'(n_last - base_last), 32'd2);

      // 6: reset mid-frame with a committed frame waiting
      m_axis_tready = 1'b0;
      base = n_out;
      send_frame(8'd2, 8'h01, 8'h01, 8'h00);
      tick(3);
      drive_byte(8'hA5); drive_byte(8'h05); drive_byte(8'h01); drive_byte(8'h02);
      exp_q.delete();
      model_occ = 0;
      irst = 1'b1;
      tick(1);
      irst = 1'b0;
      @(negedge iclk);
      check("t6_tvalid_after_rst", 32'(m_axis_tvalid), 32'd0);
      check("t6_s_tready_in_rst", 32'(s_axis_tready), 32'd0);
      @(posedge iclk); #1;
      @(negedge iclk);
      check("t6_s_tready_back", 32'(s_axis_tready), 32'd1);
      @(posedge iclk); #1;
      m_axis_tready = 1'b1;
      tick(10);
      check("t6_nothing_out", 32'(n_out - base), 32'd0);
      send_frame(8'd3, 8'h11, 8'h11, 8'h00);
      tick(10);
      check("t6_count", 32'(n_out - base), 32'd3);

      tick(20);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sv_uart_frame_rx.md
Name: sv_uart_frame_rx

Overview:
- Downstream consumer of the UART receiver's byte AXI-stream. Parses bytes into framed packets: SYNC, LEN, LEN payload bytes, CHK.
- Store-and-forward: payload is held in a commit/rewind buffer and released on m_axis, with tlast, only after the checksum verifies.
- Bad, oversize, overflowed or timed-out frames are dropped whole, and a one-cycle error pulse is raised for each.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 64, largest legal LEN value (1..255).
- BUF_AW, 7, buffer address width; depth is 2**BUF_AW. Elaboration check: 2**BUF_AW >= MAX_LEN.
- TMO_W, 24, inter-byte timeout counter width.

Ports:
- iclk  in  1  clock
- irst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  8  byte from UART receiver
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accept
- m_axis_tdata  out  8  payload byte
- m_axis_tvalid  out  1  payload valid
- m_axis_tready  in  1  consumer ready
- m_axis_tlast  out  1  last payload byte of frame
- itimeout  in  TMO_W  max idle clocks between bytes inside a frame; 0 disables
- oframe_ok  out  1  pulse: frame committed
- oerr_chk  out  1  pulse: checksum mismatch
- oerr_len  out  1  pulse: LEN==0 or LEN>MAX_LEN
- oerr_ovf  out  1  pulse: buffer full during payload
- oerr_tmo  out  1  pulse: inter-byte timeout

Behaviour:
- Reset values: all outputs 0, state HUNT, all pointers 0, buffer contents discarded. s_axis_tready is registered: 0 during reset, 1 from the first cycle after. The decoder never stalls the receiver, which has no buffering.
- Byte accepted = s_axis_tvalid & s_axis_tready.
- State machine, advanced only on accepted bytes (timeout excepted):
  - HUNT: byte==SYNC_BYTE -> LEN; any other byte is ignored.
  - LEN: byte==0 or >MAX_LEN -> oerr_len, HUNT. The offending byte is not rechecked as SYNC. Otherwise latch len, sum <= byte, cnt <= 0 -> PAYLOAD.
  - PAYLOAD: if buffer has space, write {last=(cnt==len-1), byte} at wr_ptr; wr_ptr++; sum += byte (mod 256). At cnt==len-1 -> CHK. If no space: wr_ptr <= wr_cmt, oerr_ovf, skip_cnt <= len-cnt (remaining payload plus CHK) -> SKIP.
  - A SYNC_BYTE value inside the payload is plain data; there is no resync.
  - CHK: byte==sum -> wr_cmt <= wr_ptr, oframe_ok, HUNT. Else wr_ptr <= wr_cmt, oerr_chk, HUNT.
  - SKIP: decrement skip_cnt per byte; at 1 -> HUNT. Timeout also applies here.
- Timeout: idle counter runs in every state except HUNT, cleared on each accepted byte and on entry to LEN. When counter==itimeout and itimeout!=0: wr_ptr <= wr_cmt, oerr_tmo, HUNT. A byte accepted in the same cycle wins, and timeout does not fire.
- Buffer pointers are BUF_AW+1 bits.
  - Space check: wr_ptr - rd_ptr < 2**BUF_AW, using the speculative wr_ptr.
  - Read side sees only wr_cmt; empty when rd_ptr==wr_cmt.
  - Commit, rewind and read may coincide in one cycle without interference.
- Output: registered FWFT stage. With the output empty, m_axis_tvalid rises exactly 2 cycles after the CHK handshake cycle. The stage holds data stable while tvalid & ~tready, and streams 1 byte/cycle with tready high.
- Error and ok pulses are exactly 1 cycle, registered, and mutually exclusive per cycle.
- Reset mid-frame or mid-output drops everything, including committed frames; tvalid goes to 0 the cycle after irst.

Decomposition:
- Package sv_uart_frame_pkg holds:
  - state enum (HUNT, LEN, PAYLOAD, CHK, SKIP);
  - default SYNC_BYTE;
  - 9-bit entry struct {last, data}.
- Sub-module sv_uart_frame_buf: commit/rewind FIFO.
  - Write port with space flag.
  - Commit and rewind strobes.
  - Read side with registered FWFT output.
- The top level holds the parser FSM, checksum and timeout.

Test Plan:
1. Good frame: A5 03 11 22 33 69 -> m_axis 11,22,33 with tlast on 33. One oframe_ok pulse. tvalid rises 2 cycles after the 69 handshake.
2. Bad checksum: A5 03 11 22 33 6A -> no m_axis output, one oerr_chk. A following good frame then passes intact.
3. Length errors: junk 00 FF, then A5 00, then A5 41 (65) -> two oerr_len, no output. A next good frame passes.
4. Timeout: itimeout=100, send A5 02 11 then 150 idle cycles -> oerr_tmo 100 cycles after the 11 byte, no output. Resend a full frame -> ok. Repeat with itimeout=0 -> no timeout fires.
5. Overflow and backpressure: m_axis_tready=0; send two good 64-byte frames, then a third -> oerr_ovf on the third frame's first payload byte, and its remaining bytes are skipped. Raise tready -> exactly 128 bytes out, tlast on bytes 64 and 128.
6. Reset mid-frame: irst during PAYLOAD with one frame committed -> tvalid 0 next cycle, nothing emitted. The next good frame is decoded correctly.
